// File: rtl/rom_stream_dumper_if.sv
// rom_stream_dumper_if: host stream and ROM controller signals of the dumper; ROM_DUMP_CHECKSUM_EN adds checksum
interface rom_stream_dumper_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 16
);
  logic dump;
  logic [ADDRESS_WIDTH-1:0] word_count;
  logic sck;
  logic [DATA_WIDTH-1:0] output_data;
  logic ack;
  logic done;
  logic rom_busy;
  logic rom_initialized;
  logic rom_request;
  logic [ADDRESS_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_read_data;
`ifdef ROM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
`endif
  modport master (
    input dump, word_count, ack, rom_busy, rom_initialized, rom_read_data,
    output sck, output_data, done, rom_request, rom_address
`ifdef ROM_DUMP_CHECKSUM_EN
    , output checksum
`endif
  );
  modport slave (
    output dump, word_count, ack, rom_busy, rom_initialized, rom_read_data,
    input sck, output_data, done, rom_request, rom_address
`ifdef ROM_DUMP_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/rom_stream_dumper.sv
// rom_stream_dumper: streams ROM words to a host over an sck/ack handshake; ROM_DUMP_CHECKSUM_EN adds a running checksum
module rom_stream_dumper #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  rom_stream_dumper_if.master bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  logic [2:0] state;
  logic dump_q;
  logic start;
  logic [ADDRESS_WIDTH:0] remaining;
  logic [DATA_WIDTH-1:0] data_q;
  assign start = bus.dump & ~dump_q;
  assign bus.output_data = data_q;
  // dump edge history; reset counts as dump high so a level held through reset cannot start a dump
  always_ff @(posedge clk) dump_q <= reset | bus.dump;
  // sequencer: fetch one word, present it until acked, repeat until the count runs out
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.sck <= 1'b0;
      bus.done <= 1'b0;
      bus.rom_request <= 1'b0;
      bus.rom_address <= '0;
      remaining <= '0;
      data_q <= '0;
    end else if (state != IDLE && !bus.dump) begin
      state <= IDLE;
      bus.sck <= 1'b0;
      bus.done <= 1'b0;
      bus.rom_request <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          bus.rom_address <= '0;
          remaining <= {~|bus.word_count, bus.word_count};
        end
        REQ: if (bus.rom_request && bus.rom_busy) begin
          bus.rom_request <= 1'b0;
          state <= READ;
        end else if (bus.rom_initialized && !bus.rom_busy) bus.rom_request <= 1'b1;
        READ: if (!bus.rom_busy) begin
          data_q <= bus.rom_read_data;
          bus.sck <= 1'b1;
          state <= PRESENT;
        end
        PRESENT: if (bus.ack) begin
          bus.sck <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: if (!bus.ack) begin
          if (remaining == (ADDRESS_WIDTH+1)'(1)) begin
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            bus.rom_address <= bus.rom_address + ADDRESS_WIDTH'(1);
            remaining <= remaining - (ADDRESS_WIDTH+1)'(1);
            state <= REQ;
          end
        end
        default: if (state != DONE) state <= IDLE;
      endcase
    end
  end
`ifdef ROM_DUMP_CHECKSUM_EN
  // checksum of accepted words, cleared on start and held afterwards
  always_ff @(posedge clk) begin
    if (reset) bus.checksum <= '0;
    else if (state == IDLE && start) bus.checksum <= '0;
    else if (state == PRESENT && bus.dump && bus.ack) bus.checksum <= bus.checksum + data_q;
  end
`endif
endmodule

// File: tb/tb_rom_stream_dumper.sv
// tb_rom_stream_dumper: directed checks of the ROM stream dumper against a small ROM controller model
module tb_rom_stream_dumper;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  rom_stream_dumper_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) bus();
  rom_stream_dumper #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [15:0] rom [16];
  int busy_cnt;
  logic [3:0] rd_addr;
  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int n;
  int bad;
  logic [15:0] sum;
  // ROM controller: busy for four cycles per request, data valid as busy falls
  always @(posedge clk) begin
    if (reset) bus.rom_busy <= 1'b0;
    else if (bus.rom_busy) begin
      if (busy_cnt == 0) begin
        bus.rom_busy <= 1'b0;
        bus.rom_read_data <= rom[rd_addr];
      end else busy_cnt <= busy_cnt - 1;
    end else if (bus.rom_request) begin
      bus.rom_busy <= 1'b1;
      busy_cnt <= 3;
      rd_addr <= bus.rom_address;
    end
  end
  // request and strobe must never overlap
  always @(negedge clk) if (bus.sck && bus.rom_request) overlap++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic get_word(input int dly, input logic [15:0] ed, input logic [3:0] ea);
    int k = 0;
    while (bus.sck !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("sck_rise", bus.sck, 1);
    chk("data", bus.output_data, ed);
    chk("addr", bus.rom_address, ea);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("sck_hold", bus.sck, 1);
      chk("data_hold", bus.output_data, ed);
      chk("req_low_hold", bus.rom_request, 0);
    end
    bus.ack = 1'b1;
    @(negedge clk);
    chk("sck_fall", bus.sck, 0);
    chk("req_low_release", bus.rom_request, 0);
    bus.ack = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.dump = 1'b1;
    bus.ack = 1'b0;
    bus.rom_initialized = 1'b1;
    bus.word_count = 4'd3;
    for (int i = 0; i < 16; i++) rom[i] = 16'(16'h1000 + i * 16'h0101);
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3333;
    repeat (3) @(negedge clk);
    chk("rst_sck", bus.sck, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_req", bus.rom_request, 0);
    chk("rst_addr", bus.rom_address, 0);
    chk("rst_data", bus.output_data, 0);
`ifdef ROM_DUMP_CHECKSUM_EN
    chk("rst_checksum", bus.checksum, 0);
`endif
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_dump_no_start", bus.rom_request, 0);
    bus.dump = 1'b0;
    @(negedge clk);
    bus.dump = 1'b1;
    get_word(0, 16'h1111, 4'd0);
    get_word(0, 16'h2222, 4'd1);
    get_word(0, 16'h3333, 4'd2);
    @(negedge clk);
    chk("nominal_done", bus.done, 1);
    chk("nominal_done_sck", bus.sck, 0);
`ifdef ROM_DUMP_CHECKSUM_EN
    chk("nominal_checksum", bus.checksum, 16'h6666);
`endif
    bus.dump = 1'b0;
    @(negedge clk);
    chk("done_clear", bus.done, 0);
`ifdef ROM_DUMP_CHECKSUM_EN
    chk("checksum_hold_idle", bus.checksum, 16'h6666);
`endif
    bus.rom_initialized = 1'b0;
    bus.word_count = 4'd1;
    bus.dump = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rom_request !== 1'b0) bad++;
    end
    chk("uninit_no_req", bad, 0);
    bus.rom_initialized = 1'b1;
    @(negedge clk);
    chk("uninit_first_req", bus.rom_request, 1);
    get_word(0, 16'h1111, 4'd0);
    @(negedge clk);
    chk("uninit_done", bus.done, 1);
    bus.dump = 1'b0;
    @(negedge clk);
    bus.word_count = 4'd2;
    bus.dump = 1'b1;
    get_word(10, 16'h1111, 4'd0);
    get_word(10, 16'h2222, 4'd1);
    @(negedge clk);
    chk("slow_done", bus.done, 1);
    bus.dump = 1'b0;
    @(negedge clk);
    bus.word_count = 4'd3;
    bus.dump = 1'b1;
    get_word(0, 16'h1111, 4'd0);
    n = 0;
    while (!(bus.rom_busy && !bus.rom_request) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("read_reached", bus.rom_busy & ~bus.rom_request, 1);
    bus.dump = 1'b0;
    @(negedge clk);
    chk("abort_sck", bus.sck, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_req", bus.rom_request, 0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rom_request !== 1'b0 || bus.sck !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    bus.word_count = 4'd2;
    bus.dump = 1'b1;
    get_word(0, 16'h1111, 4'd0);
    get_word(0, 16'h2222, 4'd1);
    @(negedge clk);
    chk("restart_done", bus.done, 1);
    bus.dump = 1'b0;
    @(negedge clk);
    bus.word_count = 4'd0;
    bus.dump = 1'b1;
    sum = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      get_word(0, rom[i], 4'(i));
      sum = sum + rom[i];
      if (i < 15) chk("wrap_not_done", bus.done, 0);
    end
    @(negedge clk);
    chk("wrap_done", bus.done, 1);
`ifdef ROM_DUMP_CHECKSUM_EN
    chk("wrap_checksum", bus.checksum, sum);
`endif
    bus.dump = 1'b0;
    @(negedge clk);
    bus.word_count = 4'd2;
    bus.dump = 1'b1;
    get_word(0, 16'h1111, 4'd0);
    n = 0;
    while (bus.sck !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("present_reached", bus.sck, 1);
    reset = 1'b1;
    bus.ack = 1'b1;
    @(negedge clk);
    chk("rstp_sck", bus.sck, 0);
    chk("rstp_addr", bus.rom_address, 0);
    chk("rstp_done", bus.done, 0);
    chk("rstp_req", bus.rom_request, 0);
    reset = 1'b0;
    bus.ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstp_no_restart", bus.rom_request, 0);
    chk("no_overlap", overlap, 0);
    bus.dump = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
